// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution frame writer.
// Holds the writer FSM state encoding, the buffered write-entry layout
// and the magnitude saturation helper.
package conv_pkg;

    // Entry field widths; the writer's ADDR_WIDTH/OUT_WIDTH must not exceed these.
    localparam int CONV_ADDR_WIDTH = 19;
    localparam int CONV_OUT_WIDTH  = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } writer_state_t;

    typedef struct packed {
        logic [CONV_ADDR_WIDTH-1:0] addr;
        logic [CONV_OUT_WIDTH-1:0]  data;
    } write_entry_t;

    // Clamp an unsigned magnitude to the largest value representable in out_width bits.
    function automatic logic [31:0] saturate(input logic [31:0] val, input int unsigned out_width);
        logic [31:0] max_val;
        max_val = (32'd1 << out_width) - 32'd1;
        if (val > max_val) begin
            return max_val;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/conv_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a synchronous flush.
// The head entry is visible on pop_data whenever the FIFO is not empty;
// pop_data reads as zero while empty. A pop and a push in the same cycle
// on a full FIFO both succeed (the pop frees the slot first).
module conv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign pop_data  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; flush discards all stored entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1'b1);
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/conv_frame_writer.sv
// Turns the convolution magnitude stream into raster-addressed frame-buffer
// writes: position tracking, border masking, saturation, and a small FWFT
// write buffer in front of a ready-gated write port.
// Optional build macro: WRITER_THRESHOLD_EN adds i_threshold and writes a
// binary (all-ones / zero) pixel instead of the saturated magnitude.
module conv_frame_writer
    import conv_pkg::*;
#(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int N          = 3,
    parameter int IN_WIDTH   = 15,
    parameter int OUT_WIDTH  = CONV_OUT_WIDTH,
    parameter int ADDR_WIDTH = CONV_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_frame_start,
    input  logic                  i_val_valid,
    input  logic [IN_WIDTH-1:0]   i_val,
`ifdef WRITER_THRESHOLD_EN
    input  logic [OUT_WIDTH-1:0]  i_threshold,
`endif
    output logic                  o_wr_valid,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [OUT_WIDTH-1:0]  o_wr_data,
    input  logic                  i_wr_ready,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_overflow
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_WIDTH-1:0] X_LAST    = ADDR_WIDTH'(IMG_W - 1);
    localparam logic [ADDR_WIDTH-1:0] BORDER    = ADDR_WIDTH'(N - 1);

    writer_state_t          state_r;
    writer_state_t          state_next_s;
    logic [ADDR_WIDTH-1:0]  x_r, y_r, addr_r;
    logic [ADDR_WIDTH-1:0]  pos_x_s, pos_y_s, pos_addr_s;
    logic                   accept_s;
    logic                   border_s;
    logic                   done_s;
    logic [OUT_WIDTH-1:0]   sat_s;
    logic [OUT_WIDTH-1:0]   proc_s;
    logic [OUT_WIDTH-1:0]   data_s;
    logic                   s1_valid_r;
    write_entry_t           s1_entry_r;
    write_entry_t           fifo_head_s;
    logic                   fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic                   overflow_r;
    logic                   frame_done_r;

    // A frame start in the same cycle makes this sample k=0 of the new frame.
    assign accept_s = i_val_valid && ((state_r == ACTIVE) || i_frame_start);

    // Raster position of the current sample; a frame start rewinds to the origin.
    always_comb begin
        pos_x_s    = x_r;
        pos_y_s    = y_r;
        pos_addr_s = addr_r;
        if (i_frame_start) begin
            pos_x_s    = {ADDR_WIDTH{1'b0}};
            pos_y_s    = {ADDR_WIDTH{1'b0}};
            pos_addr_s = {ADDR_WIDTH{1'b0}};
        end else begin
            pos_x_s    = x_r;
            pos_y_s    = y_r;
            pos_addr_s = addr_r;
        end
    end

    // Position counters advance on every accepted sample, even if it is later dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            x_r    <= {ADDR_WIDTH{1'b0}};
            y_r    <= {ADDR_WIDTH{1'b0}};
            addr_r <= {ADDR_WIDTH{1'b0}};
        end else if (accept_s) begin
            if (pos_x_s == X_LAST) begin
                x_r <= {ADDR_WIDTH{1'b0}};
                y_r <= pos_y_s + ADDR_WIDTH'(1'b1);
            end else begin
                x_r <= pos_x_s + ADDR_WIDTH'(1'b1);
                y_r <= pos_y_s;
            end
            addr_r <= pos_addr_s + ADDR_WIDTH'(1'b1);
        end else if (i_frame_start) begin
            x_r    <= {ADDR_WIDTH{1'b0}};
            y_r    <= {ADDR_WIDTH{1'b0}};
            addr_r <= {ADDR_WIDTH{1'b0}};
        end
    end

    // Pixel value: saturate, optionally threshold, then zero the window border.
    always_comb begin
        sat_s    = OUT_WIDTH'(saturate(32'(i_val), OUT_WIDTH));
        proc_s   = sat_s;
        border_s = (pos_x_s < BORDER) || (pos_y_s < BORDER);
`ifdef WRITER_THRESHOLD_EN
        if (sat_s >= i_threshold) begin
            proc_s = {OUT_WIDTH{1'b1}};
        end else begin
            proc_s = {OUT_WIDTH{1'b0}};
        end
`endif
        if (border_s) begin
            data_s = {OUT_WIDTH{1'b0}};
        end else begin
            data_s = proc_s;
        end
    end

    // Stage 1 register; a frame start overwrites or clears any older pending sample.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_r <= 1'b0;
            s1_entry_r <= '{addr: {CONV_ADDR_WIDTH{1'b0}}, data: {CONV_OUT_WIDTH{1'b0}}};
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_entry_r.addr <= CONV_ADDR_WIDTH'(pos_addr_s);
                s1_entry_r.data <= CONV_OUT_WIDTH'(data_s);
            end
        end
    end

    assign fifo_pop_s  = !fifo_empty_s && i_wr_ready;
    assign fifo_push_s = s1_valid_r && !i_frame_start;

    conv_sync_fifo #(
        .WIDTH ($bits(write_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (i_frame_start),
        .push      (fifo_push_s),
        .push_data (s1_entry_r),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Next-state logic; done_s marks the DRAIN to IDLE transition.
    always_comb begin
        state_next_s = state_r;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_frame_start) begin
                    state_next_s = ACTIVE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACTIVE: begin
                if (accept_s && (pos_addr_s == LAST_ADDR)) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = ACTIVE;
                end
            end
            DRAIN: begin
                if (i_frame_start) begin
                    state_next_s = ACTIVE;
                end else if (fifo_empty_s && !s1_valid_r) begin
                    state_next_s = IDLE;
                    done_s       = 1'b1;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sticky overflow (cleared by any frame start) and registered frame-done pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= done_s;
            if (i_frame_start) begin
                overflow_r <= 1'b0;
            end else if (s1_valid_r && fifo_full_s && !fifo_pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign o_wr_valid   = !fifo_empty_s;
    assign o_wr_addr    = ADDR_WIDTH'(fifo_head_s.addr);
    assign o_wr_data    = OUT_WIDTH'(fifo_head_s.data);
    assign o_busy       = (state_r != IDLE);
    assign o_frame_done = frame_done_r;
    assign o_overflow   = overflow_r;

endmodule
